stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 24 ++
 rtl/stall_ctrl_md_busy_cnt.sv | 45 ++++
 rtl/stall_ctrl.sv | 75 +++++++
 tb/tb_stall_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the stall controller: parameter defaults, stall_cause
// bit positions and the busy-counter width helper.
package stall_ctrl_pkg;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_T_W         = 3;
  localparam int DEF_CNT_W       = 32;

  localparam int CAUSE_RS = 0;
  localparam int CAUSE_RT = 1;
  localparam int CAUSE_MD = 2;
  localparam int CAUSE_W  = 3;

  // Both latencies at zero would give a zero-width counter, so keep one bit.
  function automatic int busyCntWidth(input int multCycles, input int divCycles);
    int maxCycles;
    int w;
    maxCycles = (multCycles > divCycles) ? multCycles : divCycles;
    w = $clog2(maxCycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_cnt.sv
// HI/LO unit busy window: loads the mult/div latency on an E-stage start and
// counts down; a start seen while already counting is ignored.
module md_busy_cnt
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int CW = busyCntWidth(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else if (start_i) begin
      cnt_d = is_div_i ? DIV_LOAD : MULT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: D-stage RAW hazards against E/M producers, HI/LO
// busy interlock, and a saturating count of stalled cycles.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int T_W         = DEF_T_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         D_rs_addr,
  input  logic [4:0]         D_rt_addr,
  input  logic [T_W-1:0]     D_tuse_rs,
  input  logic [T_W-1:0]     D_tuse_rt,
  input  logic               D_md_use,
  input  logic [4:0]         E_dst,
  input  logic [4:0]         M_dst,
  input  logic [T_W-1:0]     E_tnew,
  input  logic [T_W-1:0]     M_tnew,
  input  logic               E_md_start,
  input  logic               E_is_div,
  output logic               stall,
  output logic [CAUSE_W-1:0] stall_cause,
  output logic               md_busy,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic             md_busy_w;
  logic [CNT_W-1:0] stall_cnt_q;

  // $zero never carries a dependency; an all-ones Tuse can never be below Tnew.
  function automatic logic srcHazard(input logic [4:0]     src,
                                     input logic [T_W-1:0] tuse,
                                     input logic [4:0]     eDst,
                                     input logic [T_W-1:0] eTnew,
                                     input logic [4:0]     mDst,
                                     input logic [T_W-1:0] mTnew);
    return (src != 5'd0) &&
           (((src == eDst) && (tuse < eTnew)) || ((src == mDst) && (tuse < mTnew)));
  endfunction

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .start_i  (E_md_start),
    .is_div_i (E_is_div),
    .busy_o   (md_busy_w)
  );

  always_comb begin
    stall_cause           = '0;
    stall_cause[CAUSE_RS] = srcHazard(D_rs_addr, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew);
    stall_cause[CAUSE_RT] = srcHazard(D_rt_addr, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew);
    stall_cause[CAUSE_MD] = D_md_use && (md_busy_w || E_md_start);
  end

  assign stall = |stall_cause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign md_busy   = md_busy_w;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: default instance, a 4-bit counter instance
// for saturation, and a zero-latency multiply instance.
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_dst, M_dst;
  logic [2:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md_use, E_md_start, E_is_div;

  logic        stall, md_busy;
  logic [2:0]  stall_cause;
  logic [31:0] stall_cnt;

  logic        stallSat, busySat;
  logic [2:0]  causeSat;
  logic [3:0]  cntSat;

  logic        stallZero, busyZero;
  logic [2:0]  causeZero;
  logic [31:0] cntZero;

  int numChecks = 0;
  int numFails  = 0;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .T_W(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md_use(D_md_use),
    .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_is_div(E_is_div), .stall(stall),
    .stall_cause(stall_cause), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  stall_ctrl #(.CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md_use(D_md_use),
    .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_is_div(E_is_div), .stall(stallSat),
    .stall_cause(causeSat), .md_busy(busySat), .stall_cnt(cntSat)
  );

  stall_ctrl #(.MULT_CYCLES(0)) dutZero (
    .clk(clk), .reset(reset), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md_use(D_md_use),
    .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_is_div(E_is_div), .stall(stallZero),
    .stall_cause(causeZero), .md_busy(busyZero), .stall_cnt(cntZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setIdle();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_tuse_rs = 3'd0; D_tuse_rt = 3'd0;
    D_md_use = 1'b0; E_dst = 5'd0; M_dst = 5'd0; E_tnew = 3'd0; M_tnew = 3'd0;
    E_md_start = 1'b0; E_is_div = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    setIdle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    setIdle();
    reset = 1'b0;
    #1;
    numChecks++;
    if (md_busy !== 1'b0) begin numFails++; $display("[TB] FAIL reset_md_busy: got %b expected 0", md_busy); end
    numChecks++;
    if (stall_cnt !== 32'd0) begin numFails++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    numChecks++;
    if (stall !== 1'b0) begin numFails++; $display("[TB] FAIL reset_stall_idle: got %b expected 0", stall); end
    D_md_use = 1'b1; E_md_start = 1'b1;
    #1;
    numChecks++;
    if (stall_cause !== 3'b100 || stall !== 1'b1) begin
      numFails++; $display("[TB] FAIL reset_md_cause: got stall=%b cause=%b expected 1/100", stall, stall_cause);
    end
    @(posedge clk);
    #1;
    numChecks++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      numFails++; $display("[TB] FAIL reset_held_edge: got busy=%b cnt=%0d expected 0/0", md_busy, stall_cnt);
    end
    @(negedge clk);
    setIdle();
    reset = 1'b1;
  endtask

  task automatic test_rs_hazard();
    @(negedge clk);
    setIdle();
    D_rs_addr = 5'd5; D_tuse_rs = 3'd0; E_dst = 5'd5; E_tnew = 3'd1;
    #1;
    numChecks++;
    if (stall !== 1'b1 || stall_cause !== 3'b001) begin
      numFails++; $display("[TB] FAIL rs_e_hazard: got stall=%b cause=%b expected 1/001", stall, stall_cause);
    end
    @(negedge clk);
    D_rs_addr = 5'd0; E_dst = 5'd0;
    #1;
    numChecks++;
    if (stall !== 1'b0 || stall_cause !== 3'b000) begin
      numFails++; $display("[TB] FAIL rs_zero_reg: got stall=%b cause=%b expected 0/000", stall, stall_cause);
    end
    @(negedge clk);
    D_rs_addr = 5'd5; E_dst = 5'd5; D_tuse_rs = 3'd1; E_tnew = 3'd1;
    #1;
    numChecks++;
    if (stall !== 1'b0) begin numFails++; $display("[TB] FAIL rs_tuse_eq_tnew: got %b expected 0", stall); end
    @(negedge clk);
    E_dst = 5'd0; M_dst = 5'd5; M_tnew = 3'd2; D_tuse_rs = 3'd1;
    #1;
    numChecks++;
    if (stall !== 1'b1 || stall_cause !== 3'b001) begin
      numFails++; $display("[TB] FAIL rs_m_hazard: got stall=%b cause=%b expected 1/001", stall, stall_cause);
    end
    @(negedge clk);
    D_tuse_rs = 3'b111; M_tnew = 3'b111;
    #1;
    numChecks++;
    if (stall !== 1'b0) begin numFails++; $display("[TB] FAIL rs_tuse_never: got %b expected 0", stall); end
  endtask

  task automatic test_rt_hazard();
    @(negedge clk);
    setIdle();
    M_dst = 5'd8; M_tnew = 3'd1; D_rt_addr = 5'd8; D_tuse_rt = 3'd2;
    #1;
    numChecks++;
    if (stall !== 1'b0) begin numFails++; $display("[TB] FAIL rt_no_hazard: got %b expected 0", stall); end
    @(negedge clk);
    D_tuse_rt = 3'd0;
    #1;
    numChecks++;
    if (stall !== 1'b1 || stall_cause !== 3'b010) begin
      numFails++; $display("[TB] FAIL rt_m_hazard: got stall=%b cause=%b expected 1/010", stall, stall_cause);
    end
    @(negedge clk);
    D_rs_addr = 5'd8; D_tuse_rs = 3'd0;
    #1;
    numChecks++;
    if (stall_cause !== 3'b011) begin numFails++; $display("[TB] FAIL rs_rt_both: got %b expected 011", stall_cause); end
    @(negedge clk);
    D_md_use = 1'b1; E_md_start = 1'b1;
    #1;
    numChecks++;
    if (stall_cause !== 3'b111) begin numFails++; $display("[TB] FAIL all_causes: got %b expected 111", stall_cause); end
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_mult_busy();
    int stallSeen;
    int zeroSeen;
    logic expBusy;
    doReset();
    @(negedge clk);
    D_md_use = 1'b1; E_md_start = 1'b1; E_is_div = 1'b0;
    #1;
    numChecks++;
    if (stall !== 1'b1 || stall_cause !== 3'b100) begin
      numFails++; $display("[TB] FAIL mult_start_stall: got stall=%b cause=%b expected 1/100", stall, stall_cause);
    end
    stallSeen = 1;
    zeroSeen  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      E_md_start = 1'b0;
      #1;
      expBusy = (i < 5);
      numChecks++;
      if (md_busy !== expBusy) begin
        numFails++; $display("[TB] FAIL mult_busy_cycle%0d: got %b expected %b", i, md_busy, expBusy);
      end
      if (stall) stallSeen++;
      if (busyZero) zeroSeen++;
    end
    numChecks++;
    if (stallSeen != 6) begin numFails++; $display("[TB] FAIL mult_stall_cycles: got %0d expected 6", stallSeen); end
    numChecks++;
    if (stall_cnt !== 32'd6) begin numFails++; $display("[TB] FAIL mult_stall_cnt: got %0d expected 6", stall_cnt); end
    numChecks++;
    if (zeroSeen != 0) begin numFails++; $display("[TB] FAIL zero_latency_busy: got %0d busy cycles expected 0", zeroSeen); end
    setIdle();
  endtask

  task automatic test_div_reset();
    int busySeen;
    doReset();
    @(negedge clk);
    D_md_use = 1'b1; E_md_start = 1'b1; E_is_div = 1'b1;
    repeat (4) begin
      @(negedge clk);
      E_md_start = 1'b0;
    end
    #1;
    numChecks++;
    if (md_busy !== 1'b1 || stall_cnt !== 32'd4) begin
      numFails++; $display("[TB] FAIL div_before_reset: got busy=%b cnt=%0d expected 1/4", md_busy, stall_cnt);
    end
    reset = 1'b0;
    #1;
    numChecks++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      numFails++; $display("[TB] FAIL div_async_reset: got busy=%b cnt=%0d expected 0/0", md_busy, stall_cnt);
    end
    numChecks++;
    if (stall !== 1'b0) begin numFails++; $display("[TB] FAIL div_reset_stall: got %b expected 0", stall); end
    @(negedge clk);
    reset = 1'b1;
    busySeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (md_busy) busySeen++;
    end
    numChecks++;
    if (busySeen != 0 || stall_cnt !== 32'd0) begin
      numFails++; $display("[TB] FAIL div_after_release: got busy_cycles=%0d cnt=%0d expected 0/0", busySeen, stall_cnt);
    end
    setIdle();
  endtask

  task automatic test_saturation();
    doReset();
    @(negedge clk);
    D_rs_addr = 5'd5; D_tuse_rs = 3'd0; E_dst = 5'd5; E_tnew = 3'd1;
    repeat (20) @(negedge clk);
    #1;
    numChecks++;
    if (cntSat !== 4'd15) begin numFails++; $display("[TB] FAIL sat_cnt4: got %0d expected 15", cntSat); end
    numChecks++;
    if (stall_cnt !== 32'd20) begin numFails++; $display("[TB] FAIL cnt32_twenty: got %0d expected 20", stall_cnt); end
    repeat (3) @(negedge clk);
    #1;
    numChecks++;
    if (cntSat !== 4'd15) begin numFails++; $display("[TB] FAIL sat_cnt4_hold: got %0d expected 15", cntSat); end
    setIdle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] expBusy;
    expBusy = 8'b0001_1111;
    doReset();
    @(negedge clk);
    E_md_start = 1'b1; E_is_div = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      E_md_start = (i == 2);
      E_is_div   = (i == 2);
      #1;
      numChecks++;
      if (md_busy !== expBusy[i]) begin
        numFails++; $display("[TB] FAIL restart_ignored_cycle%0d: got %b expected %b", i, md_busy, expBusy[i]);
      end
    end
    setIdle();
  endtask

  initial begin
    reset = 1'b0;
    setIdle();
    test_reset();
    test_rs_hazard();
    test_rt_hazard();
    test_mult_busy();
    test_div_reset();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
